// File: rtl/nco_core.sv
// NCO datapath: shadowed phase accumulator, quarter-wave ROM and a five-stage
// stallable pipeline feeding an AXI4-Stream master. Define NCO_COS_EN for the cosine output.
module nco_core #(
  parameter int PHASE_W    = 32,
  parameter int LUT_ADDR_W = 8,
  parameter int OUT_W      = 16
) (
  input  logic                ACLK,
  input  logic                ARESET,
  input  logic [PHASE_W-1:0]  cfg_phase_inc,
  input  logic [PHASE_W-1:0]  cfg_phase_off,
  input  logic                cfg_update,
  input  logic                cfg_enable,
  input  logic                cfg_clear,
  output logic                m_axis_tvalid,
  input  logic                m_axis_tready,
  output logic [OUT_W-1:0]    m_axis_tdata,
`ifdef NCO_COS_EN
  output logic [OUT_W-1:0]    m_axis_tdata_cos,
`endif
  output logic [31:0]         wrap_cnt
);

  localparam int ROM_N = 2 ** LUT_ADDR_W;
  localparam logic signed [63:0] PI_2_Q30 = 64'sd1686629713;
  localparam logic signed [63:0] AMP = (64'sd1 <<< (OUT_W - 1)) - 64'sd1;

  // Elaboration-time sine (Q30 Taylor series) sampled at half-LSB offsets.
  function automatic logic [OUT_W-1:0] rom_val(input int k);
    logic signed [63:0] x, x2, term, sum;
    x    = (PI_2_Q30 * 64'(2 * k + 1)) >>> (LUT_ADDR_W + 1);
    x2   = (x * x) >>> 30;
    term = x;
    sum  = x;
    for (int n = 1; n < 8; n++) begin
      term = -((term * x2) >>> 30) / 64'(2 * n * (2 * n + 1));
      sum  = sum + term;
    end
    sum = (sum * AMP + (64'sd1 <<< 29)) >>> 30;
    return sum[OUT_W-1:0];
  endfunction

  logic [OUT_W-1:0] rom [ROM_N];
  for (genvar k = 0; k < ROM_N; k++) begin : g_rom
    assign rom[k] = rom_val(k);
  end

  logic [PHASE_W-1:0]    inc_sh_q, inc_sh_d, off_sh_q, off_sh_d;
  logic [PHASE_W-1:0]    acc_q, acc_d, s1_acc_q, s1_acc_d;
  logic [31:0]           wrap_q, wrap_d;
  logic                  s1_vld_q, s1_vld_d, s2_vld_q, s2_vld_d;
  logic                  s3_vld_q, s3_vld_d, s4_vld_q, s4_vld_d;
  logic                  out_vld_q, out_vld_d;
  logic [1:0]            s2_quad_q, s2_quad_d;
  logic [LUT_ADDR_W-1:0] s2_a_q, s2_a_d, s3_addr_q, s3_addr_d;
  logic                  s3_neg_q, s3_neg_d, s4_neg_q, s4_neg_d;
  logic [OUT_W-1:0]      s4_rom_q, s4_rom_d, out_data_q, out_data_d;
  logic [PHASE_W:0]      acc_sum;
  logic [PHASE_W-1:0]    ph;
  logic                  ce;
`ifdef NCO_COS_EN
  logic [LUT_ADDR_W-1:0] s3_addr_c_q, s3_addr_c_d;
  logic                  s3_neg_c_q, s3_neg_c_d, s4_neg_c_q, s4_neg_c_d;
  logic [OUT_W-1:0]      s4_rom_c_q, s4_rom_c_d, out_cos_q, out_cos_d;
  logic [1:0]            quad_c;
  assign quad_c = s2_quad_q + 2'd1;
`endif

  // AXI4-Stream: a beat transfers on a rising edge with tvalid && tready; while
  // tvalid && !tready every stage holds, and tvalid comes only from a flop.
  assign ce      = !(out_vld_q && !m_axis_tready);
  assign acc_sum = {1'b0, acc_q} + {1'b0, inc_sh_q};
  assign ph      = s1_acc_q + off_sh_q;

  always_comb begin
    inc_sh_d   = inc_sh_q;
    off_sh_d   = off_sh_q;
    acc_d      = acc_q;
    wrap_d     = wrap_q;
    s1_acc_d   = s1_acc_q;
    s1_vld_d   = s1_vld_q;
    s2_vld_d   = s2_vld_q;
    s3_vld_d   = s3_vld_q;
    s4_vld_d   = s4_vld_q;
    out_vld_d  = out_vld_q;
    s2_quad_d  = s2_quad_q;
    s2_a_d     = s2_a_q;
    s3_addr_d  = s3_addr_q;
    s3_neg_d   = s3_neg_q;
    s4_neg_d   = s4_neg_q;
    s4_rom_d   = s4_rom_q;
    out_data_d = out_data_q;
`ifdef NCO_COS_EN
    s3_addr_c_d = s3_addr_c_q;
    s3_neg_c_d  = s3_neg_c_q;
    s4_neg_c_d  = s4_neg_c_q;
    s4_rom_c_d  = s4_rom_c_q;
    out_cos_d   = out_cos_q;
`endif
    if (cfg_update) begin
      inc_sh_d = cfg_phase_inc;
      off_sh_d = cfg_phase_off;
    end
    if (ce) begin
      s1_vld_d = cfg_enable;
      s1_acc_d = acc_q;
      if (cfg_enable) begin
        acc_d = acc_sum[PHASE_W-1:0];
        if (acc_sum[PHASE_W] && (wrap_q != 32'hFFFF_FFFF)) wrap_d = wrap_q + 32'd1;
      end
      s2_vld_d   = s1_vld_q;
      s2_quad_d  = ph[PHASE_W-1 -: 2];
      s2_a_d     = ph[PHASE_W-3 -: LUT_ADDR_W];
      s3_vld_d   = s2_vld_q;
      s3_addr_d  = s2_quad_q[0] ? ~s2_a_q : s2_a_q;
      s3_neg_d   = s2_quad_q[1];
      s4_vld_d   = s3_vld_q;
      s4_rom_d   = rom[s3_addr_q];
      s4_neg_d   = s3_neg_q;
      out_vld_d  = s4_vld_q;
      out_data_d = s4_neg_q ? -s4_rom_q : s4_rom_q;
`ifdef NCO_COS_EN
      s3_addr_c_d = quad_c[0] ? ~s2_a_q : s2_a_q;
      s3_neg_c_d  = quad_c[1];
      s4_rom_c_d  = rom[s3_addr_c_q];
      s4_neg_c_d  = s3_neg_c_q;
      out_cos_d   = s4_neg_c_q ? -s4_rom_c_q : s4_rom_c_q;
`endif
    end
    // Clear beats a concurrent advance, including its wrap count.
    if (cfg_clear) begin
      acc_d     = '0;
      wrap_d    = wrap_q;
      s1_vld_d  = 1'b0;
      s2_vld_d  = 1'b0;
      s3_vld_d  = 1'b0;
      s4_vld_d  = 1'b0;
      out_vld_d = 1'b0;
    end
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      inc_sh_q   <= '0;
      off_sh_q   <= '0;
      acc_q      <= '0;
      wrap_q     <= '0;
      s1_acc_q   <= '0;
      s1_vld_q   <= 1'b0;
      s2_vld_q   <= 1'b0;
      s3_vld_q   <= 1'b0;
      s4_vld_q   <= 1'b0;
      out_vld_q  <= 1'b0;
      s2_quad_q  <= '0;
      s2_a_q     <= '0;
      s3_addr_q  <= '0;
      s3_neg_q   <= 1'b0;
      s4_neg_q   <= 1'b0;
      s4_rom_q   <= '0;
      out_data_q <= '0;
`ifdef NCO_COS_EN
      s3_addr_c_q <= '0;
      s3_neg_c_q  <= 1'b0;
      s4_neg_c_q  <= 1'b0;
      s4_rom_c_q  <= '0;
      out_cos_q   <= '0;
`endif
    end else begin
      inc_sh_q   <= inc_sh_d;
      off_sh_q   <= off_sh_d;
      acc_q      <= acc_d;
      wrap_q     <= wrap_d;
      s1_acc_q   <= s1_acc_d;
      s1_vld_q   <= s1_vld_d;
      s2_vld_q   <= s2_vld_d;
      s3_vld_q   <= s3_vld_d;
      s4_vld_q   <= s4_vld_d;
      out_vld_q  <= out_vld_d;
      s2_quad_q  <= s2_quad_d;
      s2_a_q     <= s2_a_d;
      s3_addr_q  <= s3_addr_d;
      s3_neg_q   <= s3_neg_d;
      s4_neg_q   <= s4_neg_d;
      s4_rom_q   <= s4_rom_d;
      out_data_q <= out_data_d;
`ifdef NCO_COS_EN
      s3_addr_c_q <= s3_addr_c_d;
      s3_neg_c_q  <= s3_neg_c_d;
      s4_neg_c_q  <= s4_neg_c_d;
      s4_rom_c_q  <= s4_rom_c_d;
      out_cos_q   <= out_cos_d;
`endif
    end
  end

  assign m_axis_tvalid = out_vld_q;
  assign m_axis_tdata  = out_data_q;
  assign wrap_cnt      = wrap_q;
`ifdef NCO_COS_EN
  assign m_axis_tdata_cos = out_cos_q;
`endif

endmodule

// File: tb/tb_nco_core.sv
// Directed bench for nco_core: queued expected samples, negedge monitor, final report.
`timescale 1ns/1ps
module tb_nco_core;

  logic        ACLK = 1'b0;
  logic        ARESET = 1'b1;
  logic [31:0] cfg_phase_inc = '0;
  logic [31:0] cfg_phase_off = '0;
  logic        cfg_update = 1'b0;
  logic        cfg_enable = 1'b0;
  logic        cfg_clear = 1'b0;
  logic        m_axis_tvalid;
  logic        m_axis_tready = 1'b0;
  logic [15:0] m_axis_tdata;
  logic [15:0] m_axis_tdata_cos;
  logic [31:0] wrap_cnt;

  int          checks = 0;
  int          failures = 0;
  int          accepted = 0;
  logic        mon_en = 1'b0;
  logic        stall_chk = 1'b0;
  logic [15:0] held_data;
  logic [31:0] held_wrap;
  logic [15:0] exp_q[$];
  logic [15:0] exp_cos_q[$];

  nco_core dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .cfg_phase_inc(cfg_phase_inc), .cfg_phase_off(cfg_phase_off),
    .cfg_update(cfg_update), .cfg_enable(cfg_enable), .cfg_clear(cfg_clear),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .m_axis_tdata(m_axis_tdata),
`ifdef NCO_COS_EN
    .m_axis_tdata_cos(m_axis_tdata_cos),
`endif
    .wrap_cnt(wrap_cnt)
  );

`ifndef NCO_COS_EN
  assign m_axis_tdata_cos = '0;
`endif

  // clock / reset
  always #5 ACLK = ~ACLK;

  initial begin
    #500000;
    failures++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Hand-computed samples at the four quadrant boundaries (k=0 -> 101, k=255 -> 32767).
  function automatic logic [15:0] sin_of(input int q);
    case (q % 4)
      0:       return 16'd101;
      1:       return 16'd32767;
      2:       return 16'hFF9B;  // -101
      default: return 16'h8001;  // -32767
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // driver tasks
  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic push_q(input int q);
    exp_q.push_back(sin_of(q));
    exp_cos_q.push_back(sin_of(q + 1));
  endtask

  task automatic pulse_update(input logic [31:0] inc, input logic [31:0] off);
    cfg_phase_inc = inc;
    cfg_phase_off = off;
    cfg_update = 1'b1;
    tick();
    cfg_update = 1'b0;
  endtask

  task automatic pulse_clear();
    cfg_clear = 1'b1;
    tick();
    cfg_clear = 1'b0;
  endtask

  task automatic drain(input string name, input int n_exp);
    int i;
    i = 0;
    while ((exp_q.size() != 0 || m_axis_tvalid) && i < 40) begin
      tick();
      i++;
    end
    check({name, "_left"}, exp_q.size(), 0);
    check({name, "_count"}, accepted, n_exp);
    check({name, "_idle"}, m_axis_tvalid, 1'b0);
    exp_q.delete();
    exp_cos_q.delete();
    accepted = 0;
  endtask

  // scoreboard monitor
  always @(negedge ACLK) begin
    logic [15:0] e;
    if (mon_en && m_axis_tvalid && m_axis_tready) begin
      accepted++;
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_sample: got %0h expected none", m_axis_tdata);
      end else begin
        e = exp_q.pop_front();
        check("sample", m_axis_tdata, e);
`ifdef NCO_COS_EN
        e = exp_cos_q.pop_front();
        check("cos_sample", m_axis_tdata_cos, e);
`endif
      end
    end
    if (stall_chk) begin
      check("stall_tvalid", m_axis_tvalid, 1'b1);
      check("stall_tdata", m_axis_tdata, held_data);
      check("stall_wrap", wrap_cnt, held_wrap);
    end
  end

  initial begin
    // reset state
    repeat (3) tick();
    check("reset_tvalid", m_axis_tvalid, 1'b0);
    check("reset_tdata", m_axis_tdata, 16'd0);
    check("reset_wrap", wrap_cnt, 32'd0);
    ARESET = 1'b0;
    m_axis_tready = 1'b1;
    mon_en = 1'b1;

    // quarter-turn sequence, 8 accumulator advances
    pulse_update(32'h4000_0000, 32'h0);
    for (int i = 0; i < 8; i++) push_q(i);
    cfg_enable = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      tick();
      if (i <= 5) check("latency_tvalid", m_axis_tvalid, (i == 5) ? 1'b1 : 1'b0);
    end
    cfg_enable = 1'b0;
    check("quarter_wrap", wrap_cnt, 32'd2);
    drain("quarter", 8);

    // constant offset of half a turn
    pulse_clear();
    pulse_update(32'h0, 32'h8000_0000);
    for (int i = 0; i < 6; i++) push_q(2);
    cfg_enable = 1'b1;
    repeat (6) tick();
    cfg_enable = 1'b0;
    drain("offset", 6);
    check("offset_wrap", wrap_cnt, 32'd2);

    // backpressure: 7 advances, 10-cycle stall, 3 more advances
    pulse_clear();
    pulse_update(32'h4000_0000, 32'h0);
    for (int i = 0; i < 10; i++) push_q(i);
    cfg_enable = 1'b1;
    repeat (7) tick();
    m_axis_tready = 1'b0;
    held_data = sin_of(2);
    held_wrap = 32'd3;
    stall_chk = 1'b1;
    repeat (10) tick();
    stall_chk = 1'b0;
    m_axis_tready = 1'b1;
    repeat (3) tick();
    cfg_enable = 1'b0;
    drain("bp", 10);
    check("bp_wrap", wrap_cnt, 32'd4);

    // atomic update: raw inc change ignored until the update pulse
    pulse_clear();
    pulse_update(32'h4000_0000, 32'h0);
    push_q(0); push_q(1); push_q(2); push_q(3); push_q(0);
    push_q(1); push_q(2); push_q(0); push_q(2); push_q(0);
    cfg_enable = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (i == 1) cfg_phase_inc = 32'h8000_0000;
      if (i == 5) cfg_update = 1'b1;
      if (i == 6) cfg_update = 1'b0;
    end
    cfg_enable = 1'b0;
    drain("atomic", 10);
    check("atomic_wrap", wrap_cnt, 32'd7);

    // clear mid-stream with enable held
    pulse_clear();
    pulse_update(32'h4000_0000, 32'h0);
    push_q(0); push_q(1);
    cfg_enable = 1'b1;
    repeat (6) tick();
    cfg_clear = 1'b1;
    tick();
    cfg_clear = 1'b0;
    check("clear_tvalid", m_axis_tvalid, 1'b0);
    for (int i = 0; i < 4; i++) push_q(i);
    for (int i = 1; i <= 4; i++) begin
      tick();
      check("clear_refill", m_axis_tvalid, 1'b0);
    end
    cfg_enable = 1'b0;
    tick();
    check("clear_restart", m_axis_tvalid, 1'b1);
    drain("clear", 6);
    check("clear_wrap", wrap_cnt, 32'd9);

    // reset mid-stream
    mon_en = 1'b0;
    pulse_clear();
    cfg_enable = 1'b1;
    repeat (7) tick();
    ARESET = 1'b1;
    cfg_enable = 1'b0;
    tick();
    ARESET = 1'b0;
    check("rst_tvalid", m_axis_tvalid, 1'b0);
    check("rst_tdata", m_axis_tdata, 16'd0);
    check("rst_wrap", wrap_cnt, 32'd0);
    exp_q.delete();
    exp_cos_q.delete();
    accepted = 0;
    mon_en = 1'b1;
    repeat (8) tick();
    check("rst_idle", m_axis_tvalid, 1'b0);
    pulse_update(32'h4000_0000, 32'h0);
    for (int i = 0; i < 4; i++) push_q(i);
    cfg_enable = 1'b1;
    repeat (4) tick();
    cfg_enable = 1'b0;
    drain("rst", 4);
    check("rst_wrap_after", wrap_cnt, 32'd1);

    // final report
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
